// File: rtl/aor3000_defs.sv
// ---------------------------------------------------------------------------
// aor3000_defs
// Shared definitions for the R3000 instruction-fetch front end.
//   - fetch exception codes (shared with the exception unit)
//   - fetch FSM state encodings
//   - reset vector, used by benches to seed the PC
//   - buffer entry type and an alignment helper
// ---------------------------------------------------------------------------
package aor3000_defs;

    // Fetch exception codes carried alongside each buffered instruction
    localparam logic [1:0] FETCH_EXC_NONE = 2'b00;
    localparam logic [1:0] FETCH_EXC_ADEL = 2'b01;
    localparam logic [1:0] FETCH_EXC_IBE  = 2'b10;

    // Boot ROM entry point of the R3000
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_e;

    // One decode-bound entry: word, its PC and any fetch exception
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  exc;
    } fetch_entry_t;

    // Instruction fetches must be word aligned
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/aor3000_fetch_watchdog.sv
// ---------------------------------------------------------------------------
// aor3000_fetch_watchdog
// Counts cycles spent waiting for an instruction-memory ack and flags when
// the wait has lasted TIMEOUT_CYCLES cycles (expired_o is high during the
// last permitted cycle of the wait).
// Ports:
//   clk        core clock
//   rst        synchronous active-high reset
//   clear_i    restart the count from zero (new request issued)
//   enable_i   count this cycle (request outstanding)
//   expired_o  wait has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module aor3000_fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;

    assign expired_o = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Next count: clear wins, and the counter parks once it has expired so it
    // can never wrap back into an in-range value.
    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (enable_i && !expired_o) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/aor3000_fetch_stage.sv
// ---------------------------------------------------------------------------
// aor3000_fetch_stage
// Instruction-fetch front end of the R3000 core. Takes the PC from the PC
// counter block, issues one req/ack read per PC, buffers the result (or a
// fetch exception) in a one-deep valid/ready register for decode, and pulses
// o_PC_update once per buffer load so the PC counter advances/redirects.
// Ports:
//   clk, rst               core clock, synchronous active-high reset
//   i_PC_counter           current fetch PC
//   i_pc_kill_instruction  discard any fetch not yet transferred to decode
//   o_PC_update            one-cycle pulse: PC consumed
//   o_imem_req/addr        read request and word address to memory
//   i_imem_ack/rdata/error read completion, data and bus error
//   o_instr_valid          buffer holds an entry for decode
//   o_instr/o_instr_pc     buffered word (0 on exception) and its PC
//   o_fetch_exc            00 none, 01 AdEL, 10 IBE
//   i_decode_ready         decode accepts the buffered entry
// ---------------------------------------------------------------------------
module aor3000_fetch_stage
    import aor3000_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_PC_counter,
    input  logic        i_pc_kill_instruction,
    output logic        o_PC_update,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_error,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic [1:0]  o_fetch_exc,
    input  logic        i_decode_ready
);

    fetch_state_e state_q, state_d;
    logic         kill_pending_q, kill_pending_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;
    logic         pc_update_q, pc_update_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    logic transfer;
    logic issue;
    logic ack_seen;
    logic discard;

    aor3000_fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (TIMER_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    assign transfer = valid_q & i_decode_ready;

    // A new fetch may start only when the buffer will be free next cycle and
    // the PC counter has already acted on the previous o_PC_update pulse.
    assign issue    = (!valid_q || i_decode_ready) && !pc_update_q;
    assign ack_seen = i_imem_ack & req_q;
    assign discard  = kill_pending_q | i_pc_kill_instruction;

    // Next-state and buffer logic. The buffer drains on a transfer and is
    // flushed by a kill unless decode takes it in the same cycle; a load
    // later in this block overrides the drain.
    always_comb begin
        state_d        = state_q;
        kill_pending_d = kill_pending_q;
        req_d          = req_q;
        addr_d         = addr_q;
        valid_d        = valid_q;
        entry_d        = entry_q;
        pc_update_d    = 1'b0;
        timer_clear    = 1'b0;
        timer_enable   = 1'b0;

        if (transfer || (valid_q && i_pc_kill_instruction)) begin
            valid_d = 1'b0;
        end

        case (state_q)
            FETCH_IDLE: begin
                if (issue) begin
                    if (is_word_aligned(i_PC_counter)) begin
                        req_d          = 1'b1;
                        addr_d         = i_PC_counter;
                        timer_clear    = 1'b1;
                        kill_pending_d = 1'b0;
                        state_d        = FETCH_REQ;
                    end else begin
                        valid_d     = 1'b1;
                        entry_d     = '{instr: 32'h0, pc: i_PC_counter, exc: FETCH_EXC_ADEL};
                        pc_update_d = 1'b1;
                    end
                end
            end

            FETCH_REQ: begin
                timer_enable = 1'b1;
                if (ack_seen || timer_expired) begin
                    req_d          = 1'b0;
                    kill_pending_d = 1'b0;
                    state_d        = FETCH_IDLE;
                    if (!discard) begin
                        valid_d     = 1'b1;
                        pc_update_d = 1'b1;
                        if (ack_seen && !i_imem_error) begin
                            entry_d = '{instr: i_imem_rdata, pc: addr_q, exc: FETCH_EXC_NONE};
                        end else begin
                            entry_d = '{instr: 32'h0, pc: addr_q, exc: FETCH_EXC_IBE};
                        end
                    end
                end else if (i_pc_kill_instruction) begin
                    kill_pending_d = 1'b1;
                end
            end

            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; every output is driven straight from here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FETCH_IDLE;
            kill_pending_q <= 1'b0;
            req_q          <= 1'b0;
            addr_q         <= 32'h0;
            valid_q        <= 1'b0;
            entry_q        <= '0;
            pc_update_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            kill_pending_q <= kill_pending_d;
            req_q          <= req_d;
            addr_q         <= addr_d;
            valid_q        <= valid_d;
            entry_q        <= entry_d;
            pc_update_q    <= pc_update_d;
        end
    end

    assign o_PC_update   = pc_update_q;
    assign o_imem_req    = req_q;
    assign o_imem_addr   = addr_q;
    assign o_instr_valid = valid_q;
    assign o_instr       = entry_q.instr;
    assign o_instr_pc    = entry_q.pc;
    assign o_fetch_exc   = entry_q.exc;

endmodule

// File: tb/tb_aor3000_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_aor3000_fetch_stage
// Directed bench for the fetch stage with a transaction-level reference
// model that is compared against the DUT on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_aor3000_fetch_stage;
    import aor3000_defs::*;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcCounter = RESET_VECTOR;
    logic        kill = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        busError = 1'b0;
    logic        decodeReady = 1'b0;

    logic        pcUpdate;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [1:0]  fetchExc;

    int compareCount = 0;
    int errorCount   = 0;

    aor3000_fetch_stage #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .TIMER_W        (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_PC_counter          (pcCounter),
        .i_pc_kill_instruction (kill),
        .o_PC_update           (pcUpdate),
        .o_imem_req            (imemReq),
        .o_imem_addr           (imemAddr),
        .i_imem_ack            (ack),
        .i_imem_rdata          (rdata),
        .i_imem_error          (busError),
        .o_instr_valid         (instrValid),
        .o_instr               (instr),
        .o_instr_pc            (instrPc),
        .o_fetch_exc           (fetchExc),
        .i_decode_ready        (decodeReady)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %08h, expected %08h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle's worth of inputs, then step past the next rising edge
    task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic k,
                                 input logic a, input logic [31:0] d, input logic e,
                                 input logic rdy);
        rst         = r;
        pcCounter   = pc;
        kill        = k;
        ack         = a;
        rdata       = d;
        busError    = e;
        decodeReady = rdy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: an in-flight fetch record plus the expected decode
    // buffer contents, advanced once per clock from the bench inputs.
    typedef struct {
        bit          valid;
        logic [31:0] word;
        logic [31:0] pc;
        logic [1:0]  exc;
    } entry_t;

    bit          mStarted = 0;
    bit          mBusy    = 0;
    bit          mKilled  = 0;
    int          mWaited  = 0;
    logic [31:0] mAddr    = 32'h0;
    bit          mUpd     = 0;
    entry_t      mBuf     = '{0, 32'h0, 32'h0, 2'b00};
    entry_t      nextBuf;
    bit          nextUpd;

    always @(posedge clk) begin
        if (rst) begin
            mStarted = 1;
            mBusy    = 0;
            mKilled  = 0;
            mWaited  = 0;
            mAddr    = 32'h0;
            mUpd     = 0;
            mBuf     = '{0, 32'h0, 32'h0, 2'b00};
        end else begin
            nextBuf = mBuf;
            nextUpd = 0;
            if (mBuf.valid && (decodeReady || kill)) nextBuf.valid = 0;
            if (mBusy) begin
                if (ack || mWaited == TIMEOUT - 1) begin
                    if (!(mKilled || kill)) begin
                        if (ack && !busError) nextBuf = '{1, rdata, mAddr, 2'b00};
                        else                  nextBuf = '{1, 32'h0, mAddr, 2'b10};
                        nextUpd = 1;
                    end
                    mBusy = 0;
                end else begin
                    mWaited = mWaited + 1;
                    mKilled = mKilled || kill;
                end
            end else if ((!mBuf.valid || decodeReady) && !mUpd) begin
                if (pcCounter % 4 != 0) begin
                    nextBuf = '{1, 32'h0, pcCounter, 2'b01};
                    nextUpd = 1;
                end else begin
                    mBusy   = 1;
                    mAddr   = pcCounter;
                    mWaited = 0;
                    mKilled = 0;
                end
            end
            mBuf = nextBuf;
            mUpd = nextUpd;
        end
    end

    // Continuous comparison of the DUT against the model, away from the edge
    always @(negedge clk) begin
        if (mStarted) begin
            checkOutput("model req", {31'h0, imemReq}, {31'h0, mBusy});
            checkOutput("model addr", imemAddr, mAddr);
            checkOutput("model pc_update", {31'h0, pcUpdate}, {31'h0, mUpd});
            checkOutput("model valid", {31'h0, instrValid}, {31'h0, mBuf.valid});
            if (mBuf.valid) begin
                checkOutput("model instr", instr, mBuf.word);
                checkOutput("model instr_pc", instrPc, mBuf.pc);
                checkOutput("model exc", {30'h0, fetchExc}, {30'h0, mBuf.exc});
            end
        end
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL time_limit: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    // Directed sequence with hand-computed expectations
    initial begin
        for (int i = 0; i < 3; i++) applyStimulus(1, RESET_VECTOR, 0, 0, 0, 0, 0);
        checkOutput("reset req", {31'h0, imemReq}, 0);
        checkOutput("reset valid", {31'h0, instrValid}, 0);
        checkOutput("reset pc_update", {31'h0, pcUpdate}, 0);
        checkOutput("reset addr", imemAddr, 0);
        checkOutput("reset instr", instr, 0);
        checkOutput("reset instr_pc", instrPc, 0);
        checkOutput("reset exc", {30'h0, fetchExc}, 0);

        // Boot fetch, ack in the second request cycle
        applyStimulus(0, 32'hBFC00000, 0, 0, 0, 0, 0);
        checkOutput("boot req", {31'h0, imemReq}, 1);
        checkOutput("boot addr", imemAddr, 32'hBFC00000);
        applyStimulus(0, 32'hBFC00000, 0, 0, 0, 0, 0);
        checkOutput("boot req cycle2", {31'h0, imemReq}, 1);
        applyStimulus(0, 32'hBFC00000, 0, 1, 32'h3C1A8000, 0, 0);
        checkOutput("boot req drop", {31'h0, imemReq}, 0);
        checkOutput("boot valid", {31'h0, instrValid}, 1);
        checkOutput("boot instr", instr, 32'h3C1A8000);
        checkOutput("boot instr_pc", instrPc, 32'hBFC00000);
        checkOutput("boot exc", {30'h0, fetchExc}, 0);
        checkOutput("boot pc_update", {31'h0, pcUpdate}, 1);

        // Decode stalls for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'hBFC00004, 0, 0, 0, 0, 0);
            checkOutput("stall req", {31'h0, imemReq}, 0);
            checkOutput("stall pc_update", {31'h0, pcUpdate}, 0);
            checkOutput("stall instr", instr, 32'h3C1A8000);
        end
        applyStimulus(0, 32'hBFC00004, 0, 0, 0, 0, 1);
        checkOutput("after transfer valid", {31'h0, instrValid}, 0);
        checkOutput("after transfer req", {31'h0, imemReq}, 1);
        checkOutput("after transfer addr", imemAddr, 32'hBFC00004);

        // Kill one cycle into the request, ack arrives afterwards
        applyStimulus(0, 32'h80000080, 0, 0, 0, 0, 1);
        applyStimulus(0, 32'h80000080, 1, 0, 0, 0, 1);
        applyStimulus(0, 32'h80000080, 0, 1, 32'hDEADBEEF, 0, 1);
        checkOutput("killed valid", {31'h0, instrValid}, 0);
        checkOutput("killed pc_update", {31'h0, pcUpdate}, 0);
        applyStimulus(0, 32'h80000080, 0, 0, 0, 0, 1);
        checkOutput("redirect addr", imemAddr, 32'h80000080);
        applyStimulus(0, 32'h80000080, 0, 1, 32'h24080001, 0, 1);
        checkOutput("redirect instr", instr, 32'h24080001);

        // Misaligned PC raises AdEL without a request
        applyStimulus(0, 32'h80000002, 0, 0, 0, 0, 1);
        applyStimulus(0, 32'h80000002, 0, 0, 0, 0, 1);
        checkOutput("adel req", {31'h0, imemReq}, 0);
        checkOutput("adel valid", {31'h0, instrValid}, 1);
        checkOutput("adel exc", {30'h0, fetchExc}, 1);
        checkOutput("adel instr", instr, 0);
        checkOutput("adel instr_pc", instrPc, 32'h80000002);
        checkOutput("adel pc_update", {31'h0, pcUpdate}, 1);

        // No ack: request held exactly TIMEOUT cycles, then IBE
        applyStimulus(0, 32'h80000100, 0, 0, 0, 0, 1);
        applyStimulus(0, 32'h80000100, 0, 0, 0, 0, 1);
        checkOutput("timeout req first", {31'h0, imemReq}, 1);
        for (int i = 1; i < TIMEOUT; i++) begin
            applyStimulus(0, 32'h80000100, 0, 0, 0, 0, 1);
            checkOutput("timeout req held", {31'h0, imemReq}, 1);
        end
        applyStimulus(0, 32'h80000100, 0, 0, 0, 0, 0);
        checkOutput("timeout req drop", {31'h0, imemReq}, 0);
        checkOutput("timeout exc", {30'h0, fetchExc}, 2);
        checkOutput("timeout instr", instr, 0);
        checkOutput("timeout instr_pc", instrPc, 32'h80000100);
        applyStimulus(0, 32'h80000100, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h80000100, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h80000100, 0, 1, 32'h11111111, 0, 0);
        checkOutput("late ack instr", instr, 0);
        checkOutput("late ack req", {31'h0, imemReq}, 0);

        // Bus error on ack
        applyStimulus(0, 32'h80000200, 0, 0, 0, 0, 1);
        applyStimulus(0, 32'h80000200, 0, 1, 32'hABCD1234, 1, 0);
        checkOutput("ibe exc", {30'h0, fetchExc}, 2);
        checkOutput("ibe instr", instr, 0);

        // Kill coincident with ack
        applyStimulus(0, 32'h80000300, 0, 0, 0, 0, 1);
        applyStimulus(0, 32'h80000300, 0, 0, 0, 0, 1);
        applyStimulus(0, 32'h80000300, 1, 1, 32'hCAFEF00D, 0, 1);
        checkOutput("kill+ack valid", {31'h0, instrValid}, 0);
        checkOutput("kill+ack pc_update", {31'h0, pcUpdate}, 0);

        // Reset in the middle of a request; ack during reset is ignored
        applyStimulus(0, 32'h80000300, 0, 0, 0, 0, 1);
        checkOutput("pre-reset req", {31'h0, imemReq}, 1);
        applyStimulus(1, 32'h80000300, 0, 0, 0, 0, 1);
        checkOutput("mid-req reset req", {31'h0, imemReq}, 0);
        checkOutput("mid-req reset addr", imemAddr, 0);
        applyStimulus(1, 32'h80000300, 0, 1, 32'h0BADF00D, 0, 1);
        checkOutput("reset ack valid", {31'h0, instrValid}, 0);

        // Kill flushes a stalled buffer
        applyStimulus(0, 32'h80000300, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h80000300, 0, 1, 32'h00000021, 0, 0);
        checkOutput("flush setup valid", {31'h0, instrValid}, 1);
        applyStimulus(0, 32'h80000304, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h80000304, 1, 0, 0, 0, 0);
        checkOutput("flush valid", {31'h0, instrValid}, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h80000304, 0, 0, 0, 0, 1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
